// File: rtl/nanorv32_sim_monitor_pkg.sv
// Shared constants for the simulation monitor:
// register offsets, STATUS bit positions, default codes.
package nanorv32_sim_monitor_pkg;

  localparam int unsigned REG_RESULT = 'h00;
  localparam int unsigned REG_STATUS = 'h04;
  localparam int unsigned REG_CYCLES = 'h08;
  localparam int unsigned REG_CONS   = 'h10;

  localparam int ST_DONE    = 0;
  localparam int ST_PASS    = 1;
  localparam int ST_FAIL    = 2;
  localparam int ST_TIMEOUT = 3;

  localparam logic [31:0] DEF_PASS_CODE = 32'hCAFFE000;
  localparam logic [31:0] DEF_FAIL_CODE = 32'hDEADD000;

endpackage

// File: rtl/nanorv32_sim_mon_fifo.sv
// 8-bit synchronous console FIFO with fill level.
// Pointers carry one extra wrap bit to tell full from empty.
module nanorv32_sim_mon_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [7:0]             din,
  input  logic                   pop,
  output logic [7:0]             dout,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem_q [DEPTH];
  logic [AW:0] wr_q, wr_d;
  logic [AW:0] rd_q, rd_d;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) &&
                 (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign level = wr_q - rd_q;
  assign dout  = mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (push && !full)
      wr_d = wr_q + (AW+1)'(1);
    if (pop && !empty)
      rd_d = rd_q + (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full)
      mem_q[wr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/nanorv32_sim_monitor.sv
// AHB-lite simulation monitor: result/status registers,
// cycle watchdog and round-robin drained console FIFOs.
module nanorv32_sim_monitor
  import nanorv32_sim_monitor_pkg::*;
#(
  parameter int          NB_CHAN        = 2,
  parameter int          FIFO_DEPTH     = 16,
  parameter int          ADDR_W         = 8,
  parameter logic [31:0] PASS_CODE      = DEF_PASS_CODE,
  parameter logic [31:0] FAIL_CODE      = DEF_FAIL_CODE,
  parameter int unsigned TIMEOUT_CYCLES = 100000000,
  localparam int         CW = (NB_CHAN > 1) ? $clog2(NB_CHAN) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hsel,
  input  logic [1:0]        htrans,
  input  logic              hwrite,
  input  logic [ADDR_W-1:0] haddr,
  input  logic [31:0]       hwdata,
  input  logic              hready_in,
  output logic [31:0]       hrdata,
  output logic              hready_out,
  output logic              hresp,
  output logic              con_valid,
  input  logic              con_ready,
  output logic [7:0]        con_data,
  output logic [CW-1:0]     con_chan,
  output logic              con_eol,
  output logic              test_done,
  output logic              test_pass,
  output logic              test_fail,
  output logic              test_timeout
);

  localparam int          LW    = $clog2(FIFO_DEPTH) + 1;
  localparam logic [31:0] TO_M1 = 32'(TIMEOUT_CYCLES - 1);

  logic              dph_vld_q, dph_vld_d;
  logic              dph_wr_q, dph_wr_d;
  logic [ADDR_W-1:0] dph_addr_q, dph_addr_d;
  logic [31:0]       code_q, code_d;
  logic [31:0]       cyc_q, cyc_d;
  logic              done_q, done_d, pass_q, pass_d;
  logic              fail_q, fail_d, tmo_q, tmo_d;
  logic [CW-1:0]     start_q, start_d;
  logic [CW-1:0]     grant_q, grant_d;
  logic              lock_q, lock_d;

  logic [NB_CHAN-1:0] f_push, f_pop, f_empty, f_full;
  logic [7:0]         f_dout  [NB_CHAN];
  logic [LW-1:0]      f_level [NB_CHAN];

  logic              wr_cmd, stall, found;
  logic              is_result, is_status, is_cycles, cons_hit;
  logic [ADDR_W-1:0] off;
  logic [CW-1:0]     cons_ch, pick, sel;
  logic              unused_htrans0;

  assign unused_htrans0 = htrans[0];
  assign hresp          = 1'b0;
  assign test_done      = done_q;
  assign test_pass      = pass_q;
  assign test_fail      = fail_q;
  assign test_timeout   = tmo_q;

  for (genvar g = 0; g < NB_CHAN; g++) begin : g_fifo
    nanorv32_sim_mon_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (f_push[g]),
      .din   (hwdata[7:0]),
      .pop   (f_pop[g]),
      .dout  (f_dout[g]),
      .empty (f_empty[g]),
      .full  (f_full[g]),
      .level (f_level[g])
    );
  end

  always_comb begin
    off       = dph_addr_q - ADDR_W'(REG_CONS);
    is_result = dph_addr_q == ADDR_W'(REG_RESULT);
    is_status = dph_addr_q == ADDR_W'(REG_STATUS);
    is_cycles = dph_addr_q == ADDR_W'(REG_CYCLES);
    cons_hit  = (dph_addr_q >= ADDR_W'(REG_CONS)) &&
                (off[1:0] == 2'b00) &&
                (off[ADDR_W-1:2] < (ADDR_W-2)'(NB_CHAN));
    cons_ch   = off[2 +: CW];
    wr_cmd    = dph_vld_q && dph_wr_q;
    // Wait only on the full state held at the start of the cycle
    stall      = wr_cmd && cons_hit && f_full[cons_ch];
    hready_out = !stall;
    for (int i = 0; i < NB_CHAN; i++)
      f_push[i] = wr_cmd && cons_hit &&
                  (cons_ch == CW'(i)) && !f_full[i];
  end

  always_comb begin
    hrdata = '0;
    if (dph_vld_q && !dph_wr_q) begin
      unique case (1'b1)
        is_result: hrdata = code_q;
        is_status: begin
          hrdata[ST_DONE]    = done_q;
          hrdata[ST_PASS]    = pass_q;
          hrdata[ST_FAIL]    = fail_q;
          hrdata[ST_TIMEOUT] = tmo_q;
        end
        is_cycles: hrdata = cyc_q;
        cons_hit:  hrdata = 32'(f_level[cons_ch]);
        default:   hrdata = '0;
      endcase
    end
  end

  always_comb begin
    dph_vld_d  = dph_vld_q;
    dph_wr_d   = dph_wr_q;
    dph_addr_d = dph_addr_q;
    if (!stall) begin
      dph_vld_d  = hsel && htrans[1] && hready_in;
      dph_wr_d   = hwrite;
      dph_addr_d = haddr;
    end
    cyc_d  = (cyc_q == 32'hFFFF_FFFF) ? cyc_q : cyc_q + 32'd1;
    code_d = code_q;
    done_d = done_q;
    pass_d = pass_q;
    fail_d = fail_q;
    tmo_d  = tmo_q;
    if (wr_cmd && is_result) begin
      code_d = hwdata;
      if (!done_q && hwdata == PASS_CODE) begin
        done_d = 1'b1;
        pass_d = 1'b1;
      end else if (!done_q && hwdata == FAIL_CODE) begin
        done_d = 1'b1;
        fail_d = 1'b1;
      end
    end
    if (TIMEOUT_CYCLES != 0 && !done_d && cyc_q == TO_M1) begin
      done_d = 1'b1;
      tmo_d  = 1'b1;
    end
  end

  always_comb begin
    pick  = start_q;
    found = 1'b0;
    for (int i = 0; i < NB_CHAN; i++) begin
      if (!found && !f_empty[(int'(start_q) + i) % NB_CHAN]) begin
        pick  = CW'((int'(start_q) + i) % NB_CHAN);
        found = 1'b1;
      end
    end
    // An offered char stays put until the bench takes it
    sel       = lock_q ? grant_q : pick;
    con_valid = !f_empty[sel];
    con_data  = f_dout[sel];
    con_chan  = sel;
    con_eol   = (con_data == 8'h0A);
    f_pop     = '0;
    start_d   = start_q;
    if (con_valid && con_ready) begin
      f_pop[sel] = 1'b1;
      start_d    = (sel == CW'(NB_CHAN - 1)) ? '0 : sel + CW'(1);
    end
    lock_d  = con_valid && !con_ready;
    grant_d = sel;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dph_vld_q  <= 1'b0;
      dph_wr_q   <= 1'b0;
      dph_addr_q <= '0;
      code_q     <= '0;
      cyc_q      <= '0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
      tmo_q      <= 1'b0;
      start_q    <= '0;
      grant_q    <= '0;
      lock_q     <= 1'b0;
    end else begin
      dph_vld_q  <= dph_vld_d;
      dph_wr_q   <= dph_wr_d;
      dph_addr_q <= dph_addr_d;
      code_q     <= code_d;
      cyc_q      <= cyc_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      fail_q     <= fail_d;
      tmo_q      <= tmo_d;
      start_q    <= start_d;
      grant_q    <= grant_d;
      lock_q     <= lock_d;
    end
  end

endmodule

// File: tb/tb_nanorv32_sim_monitor.sv
// Directed bench for nanorv32_sim_monitor with a
// short watchdog so expiry can be observed.
module tb_nanorv32_sim_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic        hsel;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [7:0]  haddr;
  logic [31:0] hwdata;
  logic        hready_in;
  logic [31:0] hrdata;
  logic        hready_out;
  logic        hresp;
  logic        con_valid;
  logic        con_ready;
  logic [7:0]  con_data;
  logic [0:0]  con_chan;
  logic        con_eol;
  logic        test_done;
  logic        test_pass;
  logic        test_fail;
  logic        test_timeout;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [31:0] PASS = 32'hCAFFE000;
  localparam logic [31:0] FAILC = 32'hDEADD000;

  always #5 clk = ~clk;

  assign hready_in = hready_out;

  nanorv32_sim_monitor #(
    .NB_CHAN(2),
    .FIFO_DEPTH(16),
    .ADDR_W(8),
    .TIMEOUT_CYCLES(50)
  ) dut (
    .clk(clk),
    .rst(rst),
    .hsel(hsel),
    .htrans(htrans),
    .hwrite(hwrite),
    .haddr(haddr),
    .hwdata(hwdata),
    .hready_in(hready_in),
    .hrdata(hrdata),
    .hready_out(hready_out),
    .hresp(hresp),
    .con_valid(con_valid),
    .con_ready(con_ready),
    .con_data(con_data),
    .con_chan(con_chan),
    .con_eol(con_eol),
    .test_done(test_done),
    .test_pass(test_pass),
    .test_fail(test_fail),
    .test_timeout(test_timeout)
  );

  task automatic bus_idle();
    hsel   = 1'b0;
    htrans = 2'b00;
    hwrite = 1'b0;
    haddr  = 8'h00;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus_idle();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wr_addr(input logic [7:0] a,
                         input logic [31:0] d);
    hsel   = 1'b1;
    htrans = 2'b10;
    hwrite = 1'b1;
    haddr  = a;
    @(posedge clk);
    @(negedge clk);
    bus_idle();
    hwdata = d;
  endtask

  task automatic wr(input logic [7:0] a,
                    input logic [31:0] d);
    int n;
    wr_addr(a, d);
    n = 0;
    while (!hready_out && n < 100) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    if (!hready_out) begin
      vectors++;
      miscompares++;
      $display("FAIL wr_wait addr=%h: hready_out=%b want 1", a, hready_out);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic rd(input logic [7:0] a,
                    output logic [31:0] d);
    hsel   = 1'b1;
    htrans = 2'b10;
    hwrite = 1'b0;
    haddr  = a;
    @(posedge clk);
    @(negedge clk);
    bus_idle();
    d = hrdata;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if (hrdata !== 32'h0) begin
      miscompares++;
      $display("FAIL rst_hrdata: got %h want 0", hrdata);
    end
    vectors++;
    if ({hready_out, hresp, con_valid} !== 3'b100) begin
      miscompares++;
      $display("FAIL rst_bus: got %b want 100", {hready_out, hresp, con_valid});
    end
    vectors++;
    if ({test_done, test_pass, test_fail, test_timeout} !== 4'b0) begin
      miscompares++;
      $display("FAIL rst_status: got %b want 0000",
               {test_done, test_pass, test_fail, test_timeout});
    end
  endtask

  task automatic test_result();
    logic [31:0] d;
    do_reset();
    wr(8'h00, PASS);
    vectors++;
    if ({test_done, test_pass} !== 2'b11) begin
      miscompares++;
      $display("FAIL pass_flags: got %b want 11", {test_done, test_pass});
    end
    wr(8'h00, FAILC);
    vectors++;
    if (test_fail !== 1'b0) begin
      miscompares++;
      $display("FAIL late_fail: got %b want 0", test_fail);
    end
    rd(8'h04, d);
    vectors++;
    if (d !== 32'h3) begin
      miscompares++;
      $display("FAIL status_rd: got %h want 3", d);
    end
    rd(8'h00, d);
    vectors++;
    if (d !== FAILC) begin
      miscompares++;
      $display("FAIL last_code: got %h want %h", d, FAILC);
    end
  endtask

  task automatic test_watchdog();
    do_reset();
    for (int i = 1; i <= 50; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (i == 49) begin
        vectors++;
        if (test_timeout !== 1'b0) begin
          miscompares++;
          $display("FAIL wd_early: got %b want 0", test_timeout);
        end
      end
    end
    vectors++;
    if ({test_done, test_timeout} !== 2'b11) begin
      miscompares++;
      $display("FAIL wd_fire: got %b want 11", {test_done, test_timeout});
    end
    wr(8'h00, PASS);
    vectors++;
    if ({test_pass, test_timeout} !== 2'b01) begin
      miscompares++;
      $display("FAIL wd_then_pass: got %b want 01", {test_pass, test_timeout});
    end
  endtask

  task automatic test_full_fifo();
    logic [31:0] d;
    do_reset();
    con_ready = 1'b0;
    for (int i = 0; i < 16; i++)
      wr(8'h10, 32'(i));
    wr_addr(8'h10, 32'h77);
    vectors++;
    if (hready_out !== 1'b0) begin
      miscompares++;
      $display("FAIL full_stall: got %b want 0", hready_out);
    end
    @(posedge clk);
    @(negedge clk);
    vectors++;
    if (hready_out !== 1'b0) begin
      miscompares++;
      $display("FAIL full_stall2: got %b want 0", hready_out);
    end
    con_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    con_ready = 1'b0;
    vectors++;
    if (hready_out !== 1'b1) begin
      miscompares++;
      $display("FAIL stall_release: got %b want 1", hready_out);
    end
    vectors++;
    if (con_data !== 8'h01) begin
      miscompares++;
      $display("FAIL head_after_pop: got %h want 01", con_data);
    end
    @(posedge clk);
    @(negedge clk);
    rd(8'h10, d);
    vectors++;
    if (d !== 32'd16) begin
      miscompares++;
      $display("FAIL level_16: got %0d want 16", d);
    end
    rd(8'h18, d);
    vectors++;
    if (d !== 32'h0) begin
      miscompares++;
      $display("FAIL bad_chan_rd: got %h want 0", d);
    end
    rd(8'h0C, d);
    vectors++;
    if (d !== 32'h0) begin
      miscompares++;
      $display("FAIL unmapped_rd: got %h want 0", d);
    end
    wr(8'h18, 32'h41);
  endtask

  task automatic test_round_robin();
    logic [7:0] exp_d [4];
    logic       exp_c [4];
    exp_d = '{8'h41, 8'h78, 8'h42, 8'h79};
    exp_c = '{1'b0, 1'b1, 1'b0, 1'b1};
    do_reset();
    con_ready = 1'b0;
    wr(8'h10, 32'h41);
    wr(8'h10, 32'h42);
    wr(8'h14, 32'h78);
    wr(8'h14, 32'h79);
    con_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if ({con_valid, con_data, con_chan} !==
          {1'b1, exp_d[k], exp_c[k]}) begin
        miscompares++;
        $display("FAIL rr_%0d: got v=%b d=%h c=%0d want v=1 d=%h c=%0d",
                 k, con_valid, con_data, con_chan, exp_d[k], exp_c[k]);
      end
      @(posedge clk);
      @(negedge clk);
    end
    vectors++;
    if (con_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rr_drained: got %b want 0", con_valid);
    end
    con_ready = 1'b0;
  endtask

  task automatic test_eol_hold();
    do_reset();
    con_ready = 1'b0;
    wr(8'h14, 32'h0A);
    vectors++;
    if ({con_valid, con_eol, con_chan, con_data} !== {3'b111, 8'h0A}) begin
      miscompares++;
      $display("FAIL eol: got v=%b e=%b c=%0d d=%h want v=1 e=1 c=1 d=0a",
               con_valid, con_eol, con_chan, con_data);
    end
    wr(8'h10, 32'h51);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      @(negedge clk);
      vectors++;
      if ({con_chan, con_data} !== {1'b1, 8'h0A}) begin
        miscompares++;
        $display("FAIL hold_%0d: got c=%0d d=%h want c=1 d=0a",
                 k, con_chan, con_data);
      end
    end
    con_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    con_ready = 1'b0;
    vectors++;
    if ({con_chan, con_data, con_eol} !== {1'b0, 8'h51, 1'b0}) begin
      miscompares++;
      $display("FAIL after_hold: got c=%0d d=%h e=%b want c=0 d=51 e=0",
               con_chan, con_data, con_eol);
    end
  endtask

  task automatic test_reset_stall();
    logic [31:0] d;
    do_reset();
    con_ready = 1'b0;
    for (int i = 0; i < 16; i++)
      wr(8'h10, 32'h20 + 32'(i));
    wr_addr(8'h10, 32'h55);
    vectors++;
    if (hready_out !== 1'b0) begin
      miscompares++;
      $display("FAIL rs_stall: got %b want 0", hready_out);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    vectors++;
    if ({hready_out, con_valid} !== 2'b10) begin
      miscompares++;
      $display("FAIL rs_bus: got %b want 10", {hready_out, con_valid});
    end
    rd(8'h08, d);
    vectors++;
    if (d !== 32'd1) begin
      miscompares++;
      $display("FAIL rs_cycles: got %0d want 1", d);
    end
    rd(8'h04, d);
    vectors++;
    if (d !== 32'h0) begin
      miscompares++;
      $display("FAIL rs_status: got %h want 0", d);
    end
    rd(8'h10, d);
    vectors++;
    if (d !== 32'h0) begin
      miscompares++;
      $display("FAIL rs_level: got %0d want 0", d);
    end
  endtask

  initial begin
    rst       = 1'b1;
    hwdata    = 32'h0;
    con_ready = 1'b0;
    bus_idle();
    @(negedge clk);
    test_reset();
    test_result();
    test_watchdog();
    test_full_fifo();
    test_round_robin();
    test_eol_hold();
    test_reset_stall();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: sim did not end, want end before 200000");
    $fatal(1);
  end

endmodule
